// File: rtl/xif_coproc_alu_pkg.sv
// Shared definitions for the XIF ALU coprocessor:
// opcode/funct constants, operation enum and buffer entry layout.
package xif_coproc_alu_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] F7_ALU      = 7'b0000000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SUB  = 3'b001;
    localparam logic [2:0] F3_MUL  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b011;
    localparam logic [2:0] F3_MIN  = 3'b100;
    localparam logic [2:0] F3_MAXU = 3'b101;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_XOR,
        OP_MIN,
        OP_MAXU
    } op_e;

    typedef struct packed {
        logic        valid;
        logic        committed;
        logic        killed;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/xif_coproc_alu_exec.sv
// Combinational decode + execute for offloaded ALU instructions.
// Ports: instr, rs1, rs2 in; accept, data out.
// Macro XIF_COPROC_MUL_EN adds funct3 010 (MUL, low 32 bits).
module xif_coproc_alu_exec
    import xif_coproc_alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        accept,
    output logic [31:0] data
);

    op_e  op;
    logic unused_bits;

    // Register fields are read by the top, not here.
    assign unused_bits = ^instr[24:7];

    always_comb begin
        op = OP_NONE;
        if (instr[6:0] == OPC_CUSTOM0 && instr[31:25] == F7_ALU) begin
            case (instr[14:12])
                F3_ADD:  op = OP_ADD;
                F3_SUB:  op = OP_SUB;
                F3_XOR:  op = OP_XOR;
                F3_MIN:  op = OP_MIN;
                F3_MAXU: op = OP_MAXU;
`ifdef XIF_COPROC_MUL_EN
                F3_MUL:  op = OP_MUL;
`endif
                default: op = OP_NONE;
            endcase
        end
    end

    assign accept = (op != OP_NONE);

    always_comb begin
        data = 32'h0;
        case (op)
            OP_ADD:  data = rs1 + rs2;
            OP_SUB:  data = rs1 - rs2;
            OP_XOR:  data = rs1 ^ rs2;
            OP_MIN:  data = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;
            OP_MAXU: data = (rs1 > rs2) ? rs1 : rs2;
`ifdef XIF_COPROC_MUL_EN
            OP_MUL:  data = rs1 * rs2;
`endif
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/xif_coproc_alu.sv
// XIF ALU coprocessor: executes at issue, buffers results in order,
// releases them on commit, drops them on kill.
// Ports: issue_* (offload handshake + response), commit_*,
// result_* (in-order writeback handshake); clk, rst_n (async, low).
// Macro XIF_COPROC_MUL_EN enables the MUL operation in the exec unit.
module xif_coproc_alu
    import xif_coproc_alu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [31:0]           issue_req_instr,
    input  logic [X_ID_WIDTH-1:0] issue_req_id,
    input  logic [1:0][31:0]      issue_req_rs,
    input  logic [1:0]            issue_req_rs_valid,
    output logic                  issue_resp_accept,
    output logic                  issue_resp_writeback,
    output logic                  issue_resp_dualwrite,
    output logic                  issue_resp_dualread,
    output logic                  issue_resp_loadstore,
    output logic                  issue_resp_ecswrite,
    output logic                  issue_resp_exc,

    input  logic                  commit_valid,
    input  logic [X_ID_WIDTH-1:0] commit_id,
    input  logic                  commit_kill,

    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [X_ID_WIDTH-1:0] result_id,
    output logic [31:0]           result_data,
    output logic [4:0]            result_rd,
    output logic                  result_we,
    output logic                  result_exc,
    output logic [5:0]            result_exccode,
    output logic                  result_err,
    output logic                  result_dbg,
    output logic [2:0]            result_ecswe,
    output logic [5:0]            result_ecsdata
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    entry_t                ents [DEPTH];
    logic [X_ID_WIDTH-1:0] ids  [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW:0]           count;

    logic        accept;
    logic [31:0] exec_data;
    logic        alloc;
    logic        pop;
    logic        head_kill;
    entry_t      hd;

    xif_coproc_alu_exec u_exec (
        .instr  (issue_req_instr),
        .rs1    (issue_req_rs[0]),
        .rs2    (issue_req_rs[1]),
        .accept (accept),
        .data   (exec_data)
    );

    assign issue_resp_accept    = accept;
    assign issue_resp_writeback = accept;
    assign issue_resp_dualwrite = 1'b0;
    assign issue_resp_dualread  = 1'b0;
    assign issue_resp_loadstore = 1'b0;
    assign issue_resp_ecswrite  = 1'b0;
    assign issue_resp_exc       = 1'b0;

    // Registered count only: a pop in this cycle does not open a slot.
    assign issue_ready = rst_n
                      && (count != FULL)
                      && (issue_req_rs_valid == 2'b11);

    assign alloc = issue_valid && issue_ready && accept;

    assign hd           = ents[head];
    assign head_kill    = hd.valid && hd.killed;
    assign result_valid = hd.valid && hd.committed && !hd.killed;
    assign pop          = head_kill || (result_valid && result_ready);

    assign result_id      = ids[head];
    assign result_data    = hd.data;
    assign result_rd      = hd.rd;
    assign result_we      = (hd.rd != 5'd0);
    assign result_exc     = 1'b0;
    assign result_exccode = 6'd0;
    assign result_err     = 1'b0;
    assign result_dbg     = 1'b0;
    assign result_ecswe   = 3'd0;
    assign result_ecsdata = 6'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ents[i] <= '0;
                ids[i]  <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Only already-valid entries match, so a commit for the
            // id being allocated this cycle is dropped.
            if (commit_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ents[i].valid && ids[i] == commit_id) begin
                        if (commit_kill) ents[i].killed    <= 1'b1;
                        else             ents[i].committed <= 1'b1;
                    end
                end
            end
            if (pop) begin
                ents[head] <= '0;
                head       <= head + PW'(1);
            end
            // Tail never equals a valid head while count < DEPTH.
            if (alloc) begin
                ents[tail] <= '{valid:     1'b1,
                                committed: 1'b0,
                                killed:    1'b0,
                                rd:        issue_req_instr[11:7],
                                data:      exec_data};
                ids[tail]  <= issue_req_id;
                tail       <= tail + PW'(1);
            end
            case ({alloc, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_xif_coproc_alu.sv
// Self-checking bench for xif_coproc_alu: vector table of ALU ops
// plus directed ordering, kill, full, stall and reset sequences.
module tb_xif_coproc_alu;

    logic            clk;
    logic            rst_n;
    logic            issue_valid;
    logic            issue_ready;
    logic [31:0]     issue_req_instr;
    logic [3:0]      issue_req_id;
    logic [1:0][31:0] issue_req_rs;
    logic [1:0]      issue_req_rs_valid;
    logic            issue_resp_accept;
    logic            issue_resp_writeback;
    logic            issue_resp_dualwrite;
    logic            issue_resp_dualread;
    logic            issue_resp_loadstore;
    logic            issue_resp_ecswrite;
    logic            issue_resp_exc;
    logic            commit_valid;
    logic [3:0]      commit_id;
    logic            commit_kill;
    logic            result_valid;
    logic            result_ready;
    logic [3:0]      result_id;
    logic [31:0]     result_data;
    logic [4:0]      result_rd;
    logic            result_we;
    logic            result_exc;
    logic [5:0]      result_exccode;
    logic            result_err;
    logic            result_dbg;
    logic [2:0]      result_ecswe;
    logic [5:0]      result_ecsdata;

    xif_coproc_alu #(.DEPTH(4), .X_ID_WIDTH(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .issue_valid          (issue_valid),
        .issue_ready          (issue_ready),
        .issue_req_instr      (issue_req_instr),
        .issue_req_id         (issue_req_id),
        .issue_req_rs         (issue_req_rs),
        .issue_req_rs_valid   (issue_req_rs_valid),
        .issue_resp_accept    (issue_resp_accept),
        .issue_resp_writeback (issue_resp_writeback),
        .issue_resp_dualwrite (issue_resp_dualwrite),
        .issue_resp_dualread  (issue_resp_dualread),
        .issue_resp_loadstore (issue_resp_loadstore),
        .issue_resp_ecswrite  (issue_resp_ecswrite),
        .issue_resp_exc       (issue_resp_exc),
        .commit_valid         (commit_valid),
        .commit_id            (commit_id),
        .commit_kill          (commit_kill),
        .result_valid         (result_valid),
        .result_ready         (result_ready),
        .result_id            (result_id),
        .result_data          (result_data),
        .result_rd            (result_rd),
        .result_we            (result_we),
        .result_exc           (result_exc),
        .result_exccode       (result_exccode),
        .result_err           (result_err),
        .result_dbg           (result_dbg),
        .result_ecswe         (result_ecswe),
        .result_ecsdata       (result_ecsdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } sb_t;

    typedef struct {
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic        acc;
        logic [31:0] data;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[12];
    int   checks;
    int   passed;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7,
                                       input logic [2:0] f3,
                                       input logic [4:0] rd,
                                       input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    task automatic issue(input logic [3:0] id, input logic [31:0] instr,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic exp_acc);
        @(negedge clk);
        issue_valid        = 1'b1;
        issue_req_id       = id;
        issue_req_instr    = instr;
        issue_req_rs[0]    = a;
        issue_req_rs[1]    = b;
        issue_req_rs_valid = 2'b11;
        #1;
        chk("issue_ready", issue_ready, 1'b1);
        chk("accept", issue_resp_accept, exp_acc);
        chk("writeback", issue_resp_writeback, exp_acc);
        @(posedge clk);
        #1;
        issue_valid        = 1'b0;
        issue_req_rs_valid = 2'b00;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        @(negedge clk);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic expect_result(input string name);
        sb_t e;
        bit  got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (result_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL %s: timeout, result_valid 0 want 1", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL %s: result id %0h, none expected",
                     name, result_id);
        end else begin
            e = sb_q.pop_front();
            chk({name, ".id"}, result_id, e.id);
            chk({name, ".data"}, result_data, e.data);
            chk({name, ".rd"}, result_rd, e.rd);
            chk({name, ".we"}, result_we, e.we);
        end
        if (got) begin
            result_ready = 1'b1;
            @(posedge clk);
            #1;
            result_ready = 1'b0;
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(name, result_valid, 1'b0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        checks = 0;
        passed = 0;
        rst_n = 1'b0;
        issue_valid = 1'b0;
        issue_req_instr = '0;
        issue_req_id = '0;
        issue_req_rs = '0;
        issue_req_rs_valid = 2'b11;
        commit_valid = 1'b0;
        commit_id = '0;
        commit_kill = 1'b0;
        result_ready = 1'b0;

        vecs[0]  = '{7'h00, 3'b000, 7'h0B, 5'd1, 32'hFFFFFFFF, 32'h1,
                     1'b1, 32'h0};
        vecs[1]  = '{7'h00, 3'b001, 7'h0B, 5'd2, 32'h3, 32'h5,
                     1'b1, 32'hFFFFFFFE};
        vecs[2]  = '{7'h00, 3'b011, 7'h0B, 5'd3, 32'hF0F0F0F0,
                     32'hFF00FF00, 1'b1, 32'h0FF00FF0};
        vecs[3]  = '{7'h00, 3'b100, 7'h0B, 5'd4, 32'hFFFFFFFF, 32'h5,
                     1'b1, 32'hFFFFFFFF};
        vecs[4]  = '{7'h00, 3'b101, 7'h0B, 5'd0, 32'hFFFFFFFF, 32'h5,
                     1'b1, 32'hFFFFFFFF};
        vecs[5]  = '{7'h00, 3'b100, 7'h0B, 5'd5, 32'h7, 32'h80000000,
                     1'b1, 32'h80000000};
        vecs[6]  = '{7'h00, 3'b101, 7'h0B, 5'd6, 32'h3, 32'h80000000,
                     1'b1, 32'h80000000};
        vecs[7]  = '{7'h00, 3'b110, 7'h0B, 5'd7, 32'h1, 32'h2,
                     1'b0, 32'h0};
        vecs[8]  = '{7'h20, 3'b000, 7'h0B, 5'd8, 32'h1, 32'h2,
                     1'b0, 32'h0};
        vecs[9]  = '{7'h00, 3'b000, 7'h33, 5'd9, 32'h1, 32'h2,
                     1'b0, 32'h0};
`ifdef XIF_COPROC_MUL_EN
        vecs[10] = '{7'h00, 3'b010, 7'h0B, 5'd11, 32'h3, 32'h4,
                     1'b1, 32'd12};
`else
        vecs[10] = '{7'h00, 3'b010, 7'h0B, 5'd11, 32'h3, 32'h4,
                     1'b0, 32'h0};
`endif
        vecs[11] = '{7'h00, 3'b111, 7'h0B, 5'd12, 32'h1, 32'h2,
                     1'b0, 32'h0};

        // Reset state
        #12;
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tied_zero", {issue_resp_dualwrite, issue_resp_dualread,
                          issue_resp_loadstore, issue_resp_ecswrite,
                          issue_resp_exc, result_exc, result_exccode,
                          result_err, result_dbg, result_ecswe,
                          result_ecsdata}, 32'h0);
        issue_req_rs_valid = 2'b00;

        // ADD id=3, one-cycle commit-to-result latency
        issue(4'd3, mk(7'h00, 3'b000, 5'd10, 7'h0B), 32'd5, 32'd7, 1'b1);
        sb_q.push_back('{4'd3, 32'd12, 5'd10, 1'b1});
        commit(4'd3, 1'b0);
        chk("latency_valid", result_valid, 1'b1);
        expect_result("add_id3");

        // Table of operations and rejected encodings
        for (int i = 0; i < 12; i++) begin
            issue(4'(i), mk(vecs[i].f7, vecs[i].f3, vecs[i].rd,
                            vecs[i].opc),
                  vecs[i].a, vecs[i].b, vecs[i].acc);
            if (vecs[i].acc)
                sb_q.push_back('{4'(i), vecs[i].data, vecs[i].rd,
                                 vecs[i].rd != 5'd0});
            commit(4'(i), 1'b0);
            if (vecs[i].acc) expect_result("vec");
            else expect_quiet("vec_no_alloc", 2);
        end

        // Out-of-order commits, in-order results
        issue(4'd1, mk(7'h00, 3'b000, 5'd5, 7'h0B), 32'd1, 32'd1, 1'b1);
        issue(4'd2, mk(7'h00, 3'b001, 5'd6, 7'h0B), 32'd10, 32'd4, 1'b1);
        sb_q.push_back('{4'd1, 32'd2, 5'd5, 1'b1});
        sb_q.push_back('{4'd2, 32'd6, 5'd6, 1'b1});
        commit(4'd2, 1'b0);
        expect_quiet("order_hold", 2);
        commit(4'd1, 1'b0);
        expect_result("order_first");
        expect_result("order_second");

        // Kill
        issue(4'd4, mk(7'h00, 3'b000, 5'd7, 7'h0B), 32'd9, 32'd9, 1'b1);
        commit(4'd4, 1'b1);
        expect_quiet("killed", 3);

        // Fill to DEPTH; a 4th entry must still fit after the kill
        for (int i = 8; i < 12; i++) begin
            issue(4'(i), mk(7'h00, 3'b000, 5'(i), 7'h0B),
                  32'(i), 32'(i), 1'b1);
            sb_q.push_back('{4'(i), 32'(2 * i), 5'(i), 1'b1});
        end
        @(negedge clk);
        issue_valid        = 1'b1;
        issue_req_id       = 4'd12;
        issue_req_instr    = mk(7'h00, 3'b011, 5'd13, 7'h0B);
        issue_req_rs[0]    = 32'h00FF;
        issue_req_rs[1]    = 32'h0F0F;
        issue_req_rs_valid = 2'b11;
        commit_valid       = 1'b1;
        commit_id          = 4'd8;
        #1;
        chk("full_ready", issue_ready, 1'b0);
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("full_head_valid", result_valid, 1'b1);
        e = sb_q.pop_front();
        chk("full_head_id", result_id, e.id);
        chk("full_head_data", result_data, e.data);
        result_ready = 1'b1;
        #1;
        chk("pop_no_ready", issue_ready, 1'b0);
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("ready_after_drain", issue_ready, 1'b1);
        @(posedge clk);
        #1;
        issue_valid        = 1'b0;
        issue_req_rs_valid = 2'b00;
        sb_q.push_back('{4'd12, 32'h0FF0, 5'd13, 1'b1});
        for (int i = 9; i < 13; i++) commit(4'(i), 1'b0);
        for (int i = 0; i < 4; i++) expect_result("drain");

        // Back-pressure: fields hold while result_ready is low
        issue(4'd5, mk(7'h00, 3'b011, 5'd7, 7'h0B),
              32'hA5, 32'h0F, 1'b1);
        sb_q.push_back('{4'd5, 32'hAA, 5'd7, 1'b1});
        commit(4'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", result_valid, 1'b1);
            chk("stall_id", result_id, 4'd5);
            chk("stall_data", result_data, 32'hAA);
            chk("stall_rd", result_rd, 5'd7);
        end
        expect_result("stall_pop");

        // Reset mid-stream discards buffered entries
        issue(4'd6, mk(7'h00, 3'b000, 5'd1, 7'h0B), 32'd1, 32'd2, 1'b1);
        issue(4'd7, mk(7'h00, 3'b000, 5'd2, 7'h0B), 32'd3, 32'd4, 1'b1);
        commit(4'd6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        issue_req_rs_valid = 2'b11;
        #1;
        chk("midrst_result_valid", result_valid, 1'b0);
        chk("midrst_issue_ready", issue_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue_req_rs_valid = 2'b00;
        commit(4'd7, 1'b0);
        commit(4'd6, 1'b0);
        expect_quiet("after_reset", 4);

        // Buffer usable again after reset
        issue(4'd1, mk(7'h00, 3'b000, 5'd3, 7'h0B), 32'd2, 32'd3, 1'b1);
        sb_q.push_back('{4'd1, 32'd5, 5'd3, 1'b1});
        commit(4'd1, 1'b0);
        expect_result("post_reset");
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
